// File: rtl/pwm_pulse_determination.sv
// PWM pulse determination: turns a 7-bit duty value into a high-side / low-side
// PWM pair over a fixed number of phase steps. The duty is double-buffered and
// only changes at period boundaries. Dead time keeps both outputs low around
// every polarity change so the half-bridge never conducts shoot-through.
module pwm_pulse_determination #(
    parameter int unsigned PERIOD_STEPS = 64,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned DEADTIME     = 2
) (
    input  logic       sysclk,
    input  logic       sysrst_n,
    input  logic       enable,
    input  logic [6:0] duty_in,
    output logic       pwm_out,
    output logic       pwm_out_n,
    output logic       period_start,
    output logic [6:0] duty_active,
    output logic       clamp_flag
);

    localparam int unsigned DUTY_W  = 7;
    localparam int unsigned PHASE_W = (PERIOD_STEPS > 1) ? $clog2(PERIOD_STEPS) : 1;
    localparam int unsigned PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DT_W    = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

    localparam logic [DUTY_W-1:0]  DUTY_FULL  = DUTY_W'(PERIOD_STEPS);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PERIOD_STEPS - 1);
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(PRESCALE - 1);
    localparam logic [DT_W-1:0]    DT_LOAD    = DT_W'(DEADTIME);
    localparam logic [DT_W-1:0]    DT_ONE     = DT_W'(1);

    typedef enum logic [1:0] {
        StOff,
        StHi,
        StLo,
        StDt
    } state_e;

    // Timebase
    logic [PRE_W-1:0]   prescale_cnt_q;
    logic [PHASE_W-1:0] phase_q;
    logic               tick;

    // Duty buffering and raw compare
    logic [DUTY_W-1:0]  shadow_q;
    logic               clamp_q;
    logic               period_start_q;
    logic               raw_q;
    logic               load_evt;
    logic               over_range;
    logic [DUTY_W-1:0]  duty_clamped;
    logic [DUTY_W-1:0]  eff_duty;
    logic               raw_d;

    // Output stage
    state_e             state_q;
    logic               target_hi_q;
    logic [DT_W-1:0]    dt_cnt_q;
    logic               pwm_hi_q;
    logic               pwm_lo_q;

    // Load decision, clamping and the phase-vs-duty compare
    always_comb begin
        tick         = (prescale_cnt_q == PRE_LAST);
        load_evt     = enable && (phase_q == '0) && (prescale_cnt_q == '0);
        over_range   = (duty_in > DUTY_FULL);
        duty_clamped = over_range ? DUTY_FULL : duty_in;
        // A freshly loaded duty must act in the very cycle it is loaded
        eff_duty     = load_evt ? duty_clamped : shadow_q;
        // 7-bit compare so a full-scale duty exceeds every phase value
        raw_d        = enable && (DUTY_W'(phase_q) < eff_duty);
    end

    // Prescaler and phase counter; both parked at zero while disabled
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            prescale_cnt_q <= '0;
            phase_q        <= '0;
        end else if (!enable) begin
            prescale_cnt_q <= '0;
            phase_q        <= '0;
        end else if (tick) begin
            prescale_cnt_q <= '0;
            if (phase_q == PHASE_LAST) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + 1'b1;
            end
        end else begin
            prescale_cnt_q <= prescale_cnt_q + 1'b1;
        end
    end

    // Shadow duty, clamp indication and period strobe update on a load event
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            shadow_q       <= '0;
            clamp_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            period_start_q <= load_evt;
            if (load_evt) begin
                shadow_q <= duty_clamped;
                clamp_q  <= over_range;
            end
        end
    end

    // Raw PWM level, one cycle behind the phase it was computed from
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            raw_q <= 1'b0;
        end else begin
            raw_q <= raw_d;
        end
    end

    // Output FSM: break-before-make between the two sides, outputs registered
    // alongside the state. In DT the target follows raw_q, and any change of
    // target restarts the dead-time count.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            state_q     <= StOff;
            target_hi_q <= 1'b0;
            dt_cnt_q    <= '0;
            pwm_hi_q    <= 1'b0;
            pwm_lo_q    <= 1'b0;
        end else if (!enable) begin
            state_q     <= StOff;
            target_hi_q <= 1'b0;
            dt_cnt_q    <= '0;
            pwm_hi_q    <= 1'b0;
            pwm_lo_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    if (DEADTIME == 0) begin
                        state_q  <= StLo;
                        pwm_hi_q <= 1'b0;
                        pwm_lo_q <= 1'b1;
                    end else begin
                        state_q     <= StDt;
                        target_hi_q <= 1'b0;
                        dt_cnt_q    <= DT_LOAD;
                        pwm_hi_q    <= 1'b0;
                        pwm_lo_q    <= 1'b0;
                    end
                end
                StHi: begin
                    if (!raw_q) begin
                        if (DEADTIME == 0) begin
                            state_q  <= StLo;
                            pwm_hi_q <= 1'b0;
                            pwm_lo_q <= 1'b1;
                        end else begin
                            state_q     <= StDt;
                            target_hi_q <= 1'b0;
                            dt_cnt_q    <= DT_LOAD;
                            pwm_hi_q    <= 1'b0;
                            pwm_lo_q    <= 1'b0;
                        end
                    end
                end
                StLo: begin
                    if (raw_q) begin
                        if (DEADTIME == 0) begin
                            state_q  <= StHi;
                            pwm_hi_q <= 1'b1;
                            pwm_lo_q <= 1'b0;
                        end else begin
                            state_q     <= StDt;
                            target_hi_q <= 1'b1;
                            dt_cnt_q    <= DT_LOAD;
                            pwm_hi_q    <= 1'b0;
                            pwm_lo_q    <= 1'b0;
                        end
                    end
                end
                StDt: begin
                    if (raw_q != target_hi_q) begin
                        target_hi_q <= raw_q;
                        dt_cnt_q    <= DT_LOAD;
                    end else if (dt_cnt_q == DT_ONE) begin
                        state_q  <= target_hi_q ? StHi : StLo;
                        pwm_hi_q <= target_hi_q;
                        pwm_lo_q <= !target_hi_q;
                    end else begin
                        dt_cnt_q <= dt_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= StOff;
                    pwm_hi_q <= 1'b0;
                    pwm_lo_q <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_out      = pwm_hi_q;
    assign pwm_out_n    = pwm_lo_q;
    assign period_start = period_start_q;
    assign duty_active  = shadow_q;
    assign clamp_flag   = clamp_q;

endmodule

// File: tb/tb_pwm_pulse_determination.sv
// Bench for pwm_pulse_determination: directed scenarios with hand-computed
// counts, then randomized duty/enable/reset traffic checked every cycle
// against a behavioural model.
module tb_pwm_pulse_determination;

    localparam int PERIOD_STEPS = 64;
    localparam int PRESCALE     = 1;
    localparam int DEADTIME     = 2;
    localparam int TOTAL        = PERIOD_STEPS * PRESCALE;

    logic       sysclk = 1'b0;
    logic       sysrst_n = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] duty_in = 7'd0;
    logic       pwm_out;
    logic       pwm_out_n;
    logic       period_start;
    logic [6:0] duty_active;
    logic       clamp_flag;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_pulse_determination #(
        .PERIOD_STEPS(PERIOD_STEPS),
        .PRESCALE    (PRESCALE),
        .DEADTIME    (DEADTIME)
    ) dut (
        .sysclk      (sysclk),
        .sysrst_n    (sysrst_n),
        .enable      (enable),
        .duty_in     (duty_in),
        .pwm_out     (pwm_out),
        .pwm_out_n   (pwm_out_n),
        .period_start(period_start),
        .duty_active (duty_active),
        .clamp_flag  (clamp_flag)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. n counts enabled cycles within the period; a side of
    // the bridge is on only once the raw level has been stable (and enabled)
    // for DEADTIME+1 consecutive cycles.
    int         m_n = 0;
    int         m_cl;
    int         m_eff;
    logic       m_load;
    logic [6:0] m_shadow = 7'd0;
    logic       m_clamp = 1'b0;
    logic       m_pstart = 1'b0;
    logic       m_raw = 1'b0;
    logic       m_pwm = 1'b0;
    logic       m_pwm_n = 1'b0;
    logic       m_all_hi;
    logic       m_all_lo;
    logic       h_en  [0:DEADTIME];
    logic       h_raw [0:DEADTIME];

    initial begin
        forever begin
            @(posedge sysclk or negedge sysrst_n);
            if (!sysrst_n) begin
                m_n = 0; m_shadow = 7'd0; m_clamp = 1'b0; m_pstart = 1'b0;
                m_raw = 1'b0; m_pwm = 1'b0; m_pwm_n = 1'b0;
                for (int i = 0; i <= DEADTIME; i++) begin
                    h_en[i] = 1'b0; h_raw[i] = 1'b0;
                end
            end else begin
                m_cl   = (int'(duty_in) > PERIOD_STEPS) ? PERIOD_STEPS : int'(duty_in);
                m_load = enable && (m_n == 0);
                m_eff  = m_load ? m_cl : int'(m_shadow);
                for (int i = DEADTIME; i > 0; i--) begin
                    h_en[i] = h_en[i-1]; h_raw[i] = h_raw[i-1];
                end
                h_en[0] = enable; h_raw[0] = m_raw;
                m_all_hi = 1'b1; m_all_lo = 1'b1;
                for (int i = 0; i <= DEADTIME; i++) begin
                    if (!(h_en[i] && h_raw[i])) m_all_hi = 1'b0;
                    if (!(h_en[i] && !h_raw[i])) m_all_lo = 1'b0;
                end
                m_pwm    = m_all_hi;
                m_pwm_n  = m_all_lo;
                m_raw    = enable && ((m_n / PRESCALE) < m_eff);
                m_pstart = m_load;
                if (m_load) begin
                    m_shadow = 7'(m_cl);
                    m_clamp  = int'(duty_in) > PERIOD_STEPS;
                end
                m_n = enable ? (m_n + 1) % TOTAL : 0;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle
    initial begin
        forever begin
            @(negedge sysclk);
            chk("pwm_out", pwm_out, m_pwm);
            chk("pwm_out_n", pwm_out_n, m_pwm_n);
            chk("period_start", period_start, m_pstart);
            chk("duty_active", duty_active, m_shadow);
            chk("clamp_flag", clamp_flag, m_clamp);
            chk("never_both_high", pwm_out & pwm_out_n, 0);
        end
    end

    task automatic wait_pstart(input string name);
        int k = 0;
        do begin
            @(negedge sysclk);
            k++;
        end while (period_start !== 1'b1 && k < 200);
        chk(name, period_start, 1);
    endtask

    // Samples the current cycle and the following ones, ending on the next negedge
    task automatic count_win(input int cycles, output int hi, output int lo,
                             output int dead, output int ps);
        hi = 0; lo = 0; dead = 0; ps = 0;
        for (int i = 0; i < cycles; i++) begin
            if (pwm_out) hi++;
            if (pwm_out_n) lo++;
            if (!pwm_out && !pwm_out_n) dead++;
            if (period_start) ps++;
            @(negedge sysclk);
        end
    endtask

    int hi, lo, dead, ps, hi2, lo2, dead2, ps2;
    int r;

    initial begin
        @(negedge sysclk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_pwm_n", pwm_out_n, 0);
        chk("rst_pstart", period_start, 0);
        chk("rst_duty", duty_active, 0);
        chk("rst_clamp", clamp_flag, 0);
        @(negedge sysclk);
        sysrst_n = 1'b1; enable = 1'b1; duty_in = 7'd32;
        @(negedge sysclk);
        chk("first_pstart", period_start, 1);
        chk("first_duty", duty_active, 32);

        // Steady state at duty 32
        count_win(64, hi, lo, dead, ps);
        chk("align_p1", period_start, 1);
        count_win(64, hi, lo, dead, ps);
        chk("d32_hi", hi, 30);
        chk("d32_lo", lo, 30);
        chk("d32_dead", dead, 4);
        chk("d32_pstart", ps, 1);
        chk("d32_duty", duty_active, 32);

        // Mid-period change to 16 at phase 10
        chk("align_p2", period_start, 1);
        count_win(9, hi, lo, dead, ps);
        duty_in = 7'd16;
        count_win(55, hi2, lo2, dead2, ps2);
        chk("mid_keep_hi", hi + hi2, 30);
        chk("d16_pstart", period_start, 1);
        chk("d16_duty", duty_active, 16);
        count_win(64, hi, lo, dead, ps);
        chk("d16_hi", hi, 14);
        chk("d16_dead", dead, 4);

        // Over-range duty clamps to full scale
        duty_in = 7'd100;
        count_win(64, hi, lo, dead, ps);
        chk("d100_duty", duty_active, 64);
        chk("d100_clamp", clamp_flag, 1);
        duty_in = 7'd64;
        count_win(64, hi, lo, dead, ps);
        chk("d100_hi", hi, 61);
        chk("d100_lo", lo, 1);
        chk("d64_clamp", clamp_flag, 0);
        chk("d64_duty", duty_active, 64);
        count_win(64, hi, lo, dead, ps);
        chk("d64_hi", hi, 64);
        chk("d64_lo", lo, 0);

        // Duty 0
        duty_in = 7'd0;
        count_win(64, hi, lo, dead, ps);
        chk("d0_duty", duty_active, 0);
        count_win(64, hi, lo, dead, ps);
        chk("d0_first_hi", hi, 1);
        chk("d0_first_dead", dead, 2);
        count_win(64, hi, lo, dead, ps);
        chk("d0_lo", lo, 64);

        // Enable dropped during HI, then re-enabled
        duty_in = 7'd40;
        count_win(64, hi, lo, dead, ps);
        chk("d40_duty", duty_active, 40);
        count_win(11, hi, lo, dead, ps);
        chk("pre_drop_hi", pwm_out, 1);
        enable = 1'b0;
        @(negedge sysclk);
        chk("drop_pwm", pwm_out, 0);
        chk("drop_pwm_n", pwm_out_n, 0);
        duty_in = 7'd50;
        repeat (4) @(negedge sysclk);
        chk("off_pwm", pwm_out | pwm_out_n, 0);
        chk("off_duty_kept", duty_active, 40);
        enable = 1'b1;
        @(negedge sysclk);
        chk("reen_pstart", period_start, 1);
        chk("reen_duty", duty_active, 50);
        count_win(3, hi, lo, dead, ps);
        chk("reen_dead", dead, 3);
        chk("reen_hi", pwm_out, 1);

        // Asynchronous reset at phase 40 while high
        repeat (36) @(negedge sysclk);
        chk("pre_rst_hi", pwm_out, 1);
        #2 sysrst_n = 1'b0;
        #1;
        chk("arst_pwm", pwm_out, 0);
        chk("arst_pwm_n", pwm_out_n, 0);
        chk("arst_pstart", period_start, 0);
        chk("arst_duty", duty_active, 0);
        chk("arst_clamp", clamp_flag, 0);
        @(negedge sysclk);
        sysrst_n = 1'b1;
        @(negedge sysclk);
        chk("post_rst_pstart", period_start, 1);
        chk("post_rst_duty", duty_active, 50);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge sysclk);
            if (!sysrst_n) sysrst_n = 1'b1;
            r = int'($urandom_range(0, 199));
            if (r < 6) begin
                case ($urandom_range(0, 5))
                    0: duty_in = 7'd0;
                    1: duty_in = 7'd64;
                    2: duty_in = 7'd65;
                    3: duty_in = 7'd127;
                    default: duty_in = 7'($urandom_range(0, 127));
                endcase
            end else if (r < 8) begin
                enable = ~enable;
            end else if (r == 8 && $urandom_range(0, 3) == 0) begin
                #2 sysrst_n = 1'b0;
            end
        end
        @(negedge sysclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
